// File: rtl/big_memory_window_fetcher.sv
// Walks a rectangular window of word-pairs in a big-memory fragment, buffers each
// captured pair with its row/col tags in a small FIFO and streams them downstream.
module big_memory_window_fetcher #(
  parameter int DATA_W     = 32,
  parameter int DIM_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              iStart,
  input  logic [31:0]       iBaseAddr,
  input  logic [31:0]       iRowStride,
  input  logic [DIM_W-1:0]  iWinPairs,
  input  logic [DIM_W-1:0]  iWinRows,
  output logic [31:0]       oAddress,
  output logic              oMemRead,
  input  logic [DATA_W-1:0] iReadData1,
  input  logic [DATA_W-1:0] iReadData2,
  output logic              oPairValid,
  input  logic              iPairReady,
  output logic [DATA_W-1:0] oPairData1,
  output logic [DATA_W-1:0] oPairData2,
  output logic [DIM_W-1:0]  oPairRow,
  output logic [DIM_W-1:0]  oPairCol,
  output logic              oPairLast,
  output logic              oBusy,
  output logic              oDone
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 * DATA_W + 2 * DIM_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [DIM_W-1:0] ONE_D   = DIM_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        row_addr_q, row_addr_d;
  logic [31:0]        stride_q, stride_d;
  logic [31:0]        addr_hold_q, addr_hold_d;
  logic [DIM_W-1:0]   pairs_q, pairs_d;
  logic [DIM_W-1:0]   rows_q, rows_d;
  logic [DIM_W-1:0]   row_q, row_d;
  logic [DIM_W-1:0]   col_q, col_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];

  logic        fetch;
  logic        pop;
  logic        col_wrap;
  logic        last_pair;
  logic [31:0] pair_addr;

  // Fetch decision uses the registered count only, so a pop never frees a slot in the same cycle.
  assign fetch     = (state_q == S_FETCH) && (count_q < DEPTH_C);
  assign pop       = oPairValid && iPairReady;
  assign col_wrap  = (col_q == pairs_q - ONE_D);
  assign last_pair = col_wrap && (row_q == rows_q - ONE_D);
  assign pair_addr = row_addr_q + (32'(col_q) << 3);

  always_comb begin
    state_d     = state_q;
    row_addr_d  = row_addr_q;
    stride_d    = stride_q;
    pairs_d     = pairs_q;
    rows_d      = rows_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_hold_d = fetch ? pair_addr : addr_hold_q;
    wr_ptr_d    = fetch ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q;
    case ({fetch, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          pairs_d    = iWinPairs;
          rows_d     = iWinRows;
          stride_d   = iRowStride;
          row_addr_d = iBaseAddr;
          row_d      = '0;
          col_d      = '0;
          state_d    = (iWinPairs == '0 || iWinRows == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (fetch) begin
          if (last_pair) state_d = S_DRAIN;
          if (col_wrap) begin
            col_d      = '0;
            row_d      = row_q + ONE_D;
            row_addr_d = row_addr_q + stride_q;
          end else begin
            col_d = col_q + ONE_D;
          end
        end
      end
      S_DRAIN: begin
        if (count_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      row_addr_q  <= '0;
      stride_q    <= '0;
      addr_hold_q <= '0;
      pairs_q     <= '0;
      rows_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      row_addr_q  <= row_addr_d;
      stride_q    <= stride_d;
      addr_hold_q <= addr_hold_d;
      pairs_q     <= pairs_d;
      rows_q      <= rows_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Pair storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge Clk) begin
    if (fetch) fifo_mem[wr_ptr_q] <= {iReadData1, iReadData2, row_q, col_q, last_pair};
  end

  assign {oPairData1, oPairData2, oPairRow, oPairCol, oPairLast} = fifo_mem[rd_ptr_q];

  assign oMemRead   = fetch;
  assign oAddress   = fetch ? pair_addr : addr_hold_q;
  assign oPairValid = (count_q != '0);
  assign oBusy      = (state_q != S_IDLE);
  assign oDone      = (state_q == S_DONE);

endmodule
